// File: rtl/pmp_checker.sv
// pmp_checker: sequential PMP checker for the tinyriscv core.
// A request is snapshotted on accept. The entries are then scanned ENTRIES_PER_CYCLE at a time,
// and the lowest-index match wins. The result is held until the response is consumed.
// The first denied access is captured in sticky fault registers.
// Optional feature macro: PMP_PERF_CNT_EN adds saturating check/deny counters.
//
// state | meaning
// IDLE  | ready for a request
// SCAN  | evaluating one group of entries per cycle
// RESP  | response valid, waiting for rsp_ready_i
module pmp_checker #(
  parameter int PMP_CNT           = 16,
  parameter int ENTRIES_PER_CYCLE = 4,
  parameter int ADDR_W            = 32,
  localparam int IDX_W            = (PMP_CNT > 1) ? $clog2(PMP_CNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PMP_CNT*8-1:0]  pmpcfg_i,
  input  logic [PMP_CNT*32-1:0] pmpaddr_i,
  input  logic [1:0]            prv_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_r_i,
  input  logic                  req_w_i,
  input  logic                  req_x_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_allow_o,
  output logic                  rsp_matched_o,
  output logic [IDX_W-1:0]      rsp_idx_o,
  output logic                  fault_valid_o,
  output logic [ADDR_W-1:0]     fault_addr_o,
  output logic [1:0]            fault_type_o,
  input  logic                  fault_clr_i,
  output logic                  busy_o
`ifdef PMP_PERF_CNT_EN
  ,output logic [31:0]          check_cnt_o
  ,output logic [31:0]          deny_cnt_o
`endif
);

  localparam int EPC  = ENTRIES_PER_CYCLE;
  localparam int NGRP = PMP_CNT / EPC;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [1:0]            r_size;
  logic                  r_rd, r_wr, r_ex;
  logic [1:0]            r_prv;
  logic [PMP_CNT*8-1:0]  r_cfg;
  logic [PMP_CNT*32-1:0] r_pa;
  logic [GW-1:0]         r_grp;
  logic                  r_allow, r_matched;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_fault_valid;
  logic [ADDR_W-1:0]     r_fault_addr;
  logic [1:0]            r_fault_type;

  logic [34:0]           w_lo, w_hi, w_nbytes;
  logic                  w_hit, w_hit_allow, w_last, w_req_hs, w_rsp_hs;
  logic [IDX_W-1:0]      w_hit_idx;
  logic                  w_unused_cfg;

  // Returns {overlap, partial} of byte range lo..hi against one entry's region.
  // Region bounds use 35 bits so a full 2^34 NAPOT top and hi never wrap.
  function automatic logic [1:0] f_match(input logic [1:0] a_mode, input logic [31:0] cur,
                                         input logic [31:0] prev, input logic [34:0] lo,
                                         input logic [34:0] hi);
    logic [34:0] base, top;
    logic [31:0] m;
    logic        valid, ovl, full;
    base  = '0;
    top   = '0;
    m     = cur ^ (cur + 32'd1);
    valid = 1'b0;
    case (a_mode)
      2'b01: begin
        base  = {1'b0, prev, 2'b00};
        top   = {1'b0, cur, 2'b00};
        valid = (base < top);
      end
      2'b10: begin
        base  = {1'b0, cur, 2'b00};
        top   = base + 35'd4;
        valid = 1'b1;
      end
      2'b11: begin
        // m holds the trailing ones plus the following zero; all-ones cur yields the whole space
        base  = {1'b0, cur & ~m, 2'b00};
        top   = base + {1'b0, m, 2'b11} + 35'd1;
        valid = 1'b1;
      end
      default: valid = 1'b0;
    endcase
    ovl  = valid && (lo < top) && (hi >= base);
    full = ovl && (lo >= base) && (hi < top);
    return {ovl, ovl && !full};
  endfunction

  assign w_req_hs     = req_valid_i && (r_state == IDLE);
  assign w_rsp_hs     = rsp_ready_i && (r_state == RESP);
  assign w_last       = (r_grp == GW'(NGRP - 1));
  assign w_unused_cfg = ^r_cfg;

  assign req_ready_o   = (r_state == IDLE);
  assign rsp_valid_o   = (r_state == RESP);
  assign busy_o        = (r_state != IDLE);
  assign rsp_allow_o   = r_allow;
  assign rsp_matched_o = r_matched;
  assign rsp_idx_o     = r_idx;
  assign fault_valid_o = r_fault_valid;
  assign fault_addr_o  = r_fault_addr;
  assign fault_type_o  = r_fault_type;

  // Byte range of the snapshotted access; size 3 behaves as 4 bytes.
  always_comb begin
    w_lo = 35'(r_addr);
    case (r_size)
      2'd0:    w_nbytes = 35'd1;
      2'd1:    w_nbytes = 35'd2;
      default: w_nbytes = 35'd4;
    endcase
    w_hi = w_lo + w_nbytes - 35'd1;
  end

  // Evaluates the current group and keeps the lowest matching entry plus its permission.
  always_comb begin
    int          e;
    logic [31:0] cur, prev;
    logic [7:0]  cfg;
    logic [1:0]  mp;
    w_hit       = 1'b0;
    w_hit_idx   = '0;
    w_hit_allow = 1'b0;
    e           = 0;
    cur         = '0;
    prev        = '0;
    cfg         = '0;
    mp          = '0;
    for (int j = 0; j < EPC; j++) begin
      e    = int'(r_grp) * EPC + j;
      cur  = r_pa[e*32 +: 32];
      prev = (e == 0) ? 32'd0 : r_pa[((e == 0) ? 0 : e - 1)*32 +: 32];
      cfg  = r_cfg[e*8 +: 8];
      mp   = f_match(cfg[4:3], cur, prev, w_lo, w_hi);
      if (!w_hit && mp[1]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(e);
        if (mp[0])
          w_hit_allow = 1'b0;
        else if (r_prv == 2'b11 && !cfg[7])
          w_hit_allow = 1'b1;
        else
          w_hit_allow = (!r_rd || cfg[0]) && (!r_wr || cfg[1]) && (!r_ex || cfg[2]);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_state_nxt = SCAN;
      SCAN:    if (w_hit || w_last) w_state_nxt = RESP;
      RESP:    if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request snapshot, group counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr    <= '0;
      r_size    <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_ex      <= 1'b0;
      r_prv     <= '0;
      r_cfg     <= '0;
      r_pa      <= '0;
      r_grp     <= '0;
      r_allow   <= 1'b0;
      r_matched <= 1'b0;
      r_idx     <= '0;
    end else if (w_req_hs) begin
      r_addr <= req_addr_i;
      r_size <= req_size_i;
      r_rd   <= req_r_i;
      r_wr   <= req_w_i;
      r_ex   <= req_x_i;
      r_prv  <= prv_i;
      r_cfg  <= pmpcfg_i;
      r_pa   <= pmpaddr_i;
      r_grp  <= '0;
    end else if (r_state == SCAN) begin
      if (w_hit) begin
        r_matched <= 1'b1;
        r_idx     <= w_hit_idx;
        r_allow   <= w_hit_allow;
      end else if (w_last) begin
        r_matched <= 1'b0;
        r_idx     <= '0;
        r_allow   <= (r_prv == 2'b11);
      end else begin
        r_grp <= r_grp + GW'(1);
      end
    end
  end

  // Sticky fault capture; a deny in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_type  <= '0;
    end else if (w_rsp_hs && !r_allow && (!r_fault_valid || fault_clr_i)) begin
      r_fault_valid <= 1'b1;
      r_fault_addr  <= r_addr;
      r_fault_type  <= r_ex ? 2'd2 : (r_wr ? 2'd1 : 2'd0);
    end else if (fault_clr_i) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_type  <= '0;
    end
  end

`ifdef PMP_PERF_CNT_EN
  logic [31:0] r_check_cnt, r_deny_cnt;
  assign check_cnt_o = r_check_cnt;
  assign deny_cnt_o  = r_deny_cnt;

  // Saturating counters of completed and denied responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_check_cnt <= '0;
      r_deny_cnt  <= '0;
    end else if (fault_clr_i) begin
      r_check_cnt <= '0;
      r_deny_cnt  <= '0;
    end else if (w_rsp_hs) begin
      if (r_check_cnt != 32'hFFFF_FFFF) r_check_cnt <= r_check_cnt + 32'd1;
      if (!r_allow && r_deny_cnt != 32'hFFFF_FFFF) r_deny_cnt <= r_deny_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pmp_checker.sv
// Directed testbench for pmp_checker with hand-computed expectations.
module tb_pmp_checker;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N*8-1:0]  cfg = '0;
  logic [N*32-1:0] pa = '0;
  logic [1:0]    prv = 2'b11;
  logic          req_valid = 1'b0;
  logic          req_ready_o;
  logic [31:0]   req_addr = '0;
  logic [1:0]    req_size = '0;
  logic          req_r = 1'b0, req_w = 1'b0, req_x = 1'b0;
  logic          rsp_valid_o;
  logic          rsp_ready = 1'b0;
  logic          rsp_allow_o, rsp_matched_o;
  logic [3:0]    rsp_idx_o;
  logic          fault_valid_o;
  logic [31:0]   fault_addr_o;
  logic [1:0]    fault_type_o;
  logic          fault_clr = 1'b0;
  logic          busy_o;
`ifdef PMP_PERF_CNT_EN
  logic [31:0]   check_cnt, deny_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  pmp_checker #(.PMP_CNT(N), .ENTRIES_PER_CYCLE(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .pmpcfg_i(cfg), .pmpaddr_i(pa), .prv_i(prv),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_addr_i(req_addr),
    .req_size_i(req_size), .req_r_i(req_r), .req_w_i(req_w), .req_x_i(req_x),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_allow_o(rsp_allow_o),
    .rsp_matched_o(rsp_matched_o), .rsp_idx_o(rsp_idx_o), .fault_valid_o(fault_valid_o),
    .fault_addr_o(fault_addr_o), .fault_type_o(fault_type_o), .fault_clr_i(fault_clr),
    .busy_o(busy_o)
`ifdef PMP_PERF_CNT_EN
    , .check_cnt_o(check_cnt), .deny_cnt_o(deny_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [7:0] c, input logic [31:0] a);
    cfg[i*8 +: 8]  = c;
    pa[i*32 +: 32] = a;
  endtask

  // Issues one request and returns the number of edges from accept until rsp_valid.
  task automatic send(input logic [31:0] a, input logic [1:0] sz, input logic r, input logic w,
                      input logic x, input logic [1:0] p, output int l);
    int guard;
    @(negedge clk);
    req_addr = a; req_size = sz; req_r = r; req_w = w; req_x = x; prv = p;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    l = 0;
    while (!rsp_valid_o && l < 40) begin
      @(posedge clk);
      #1 l++;
    end
  endtask

  task automatic take_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic clr_fault();
    @(negedge clk);
    fault_clr = 1'b1;
    @(posedge clk);
    #1 fault_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_ready", 64'(req_ready_o), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_fault_valid", 64'(fault_valid_o), 64'd0);
    chk("reset_allow", 64'(rsp_allow_o), 64'd0);
    @(negedge clk) rst = 1'b1;

    // No entries enabled: M allowed after full scan, U denied.
    send(32'h8000_0000, 2'd2, 1, 0, 0, 2'b11, lat);
    chk("off_m_lat", 64'(lat), 64'd4);
    chk("off_m_allow", 64'(rsp_allow_o), 64'd1);
    chk("off_m_matched", 64'(rsp_matched_o), 64'd0);
    chk("off_m_busy", 64'(busy_o), 64'd1);
    take_rsp();
    chk("off_m_nofault", 64'(fault_valid_o), 64'd0);
    send(32'h8000_0000, 2'd2, 1, 0, 0, 2'b00, lat);
    chk("off_u_lat", 64'(lat), 64'd4);
    chk("off_u_allow", 64'(rsp_allow_o), 64'd0);
    take_rsp();
    chk("off_u_fault_valid", 64'(fault_valid_o), 64'd1);
    chk("off_u_fault_addr", 64'(fault_addr_o), 64'h8000_0000);
    chk("off_u_fault_type", 64'(fault_type_o), 64'd0);
    clr_fault();
    chk("clr_fault_valid", 64'(fault_valid_o), 64'd0);
    chk("clr_fault_addr", 64'(fault_addr_o), 64'd0);

    // NAPOT 4 KiB at 0x8000_0000, R only.
    set_entry(0, 8'h19, 32'h2000_01FF);
    send(32'h8000_0FFC, 2'd2, 1, 0, 0, 2'b00, lat);
    chk("napot_lat", 64'(lat), 64'd1);
    chk("napot_allow", 64'(rsp_allow_o), 64'd1);
    chk("napot_matched", 64'(rsp_matched_o), 64'd1);
    chk("napot_idx", 64'(rsp_idx_o), 64'd0);
    take_rsp();
    send(32'h8000_0FFC, 2'd2, 0, 1, 0, 2'b00, lat);
    chk("napot_st_allow", 64'(rsp_allow_o), 64'd0);
    take_rsp();
    chk("napot_st_type", 64'(fault_type_o), 64'd1);
    chk("napot_st_addr", 64'(fault_addr_o), 64'h8000_0FFC);
    clr_fault();
    send(32'h8000_0FFE, 2'd2, 1, 0, 0, 2'b00, lat);
    chk("straddle_matched", 64'(rsp_matched_o), 64'd1);
    chk("straddle_allow", 64'(rsp_allow_o), 64'd0);
    take_rsp();
    send(32'h8000_1000, 2'd0, 1, 0, 0, 2'b00, lat);
    chk("napot_past_end_lat", 64'(lat), 64'd4);
    chk("napot_past_end_matched", 64'(rsp_matched_o), 64'd0);
    take_rsp();
    clr_fault();

    // TOR entry 5 over [0x4000_0000, 0x4000_1000), XWR.
    cfg = '0; pa = '0;
    set_entry(4, 8'h00, 32'h1000_0000);
    set_entry(5, 8'h0F, 32'h1000_0400);
    send(32'h4000_0100, 2'd2, 0, 0, 1, 2'b01, lat);
    chk("tor_lat", 64'(lat), 64'd2);
    chk("tor_idx", 64'(rsp_idx_o), 64'd5);
    chk("tor_allow", 64'(rsp_allow_o), 64'd1);
    take_rsp();
    send(32'h4000_1000, 2'd2, 0, 0, 1, 2'b01, lat);
    chk("tor_out_matched", 64'(rsp_matched_o), 64'd0);
    chk("tor_out_allow", 64'(rsp_allow_o), 64'd0);
    take_rsp();
    chk("tor_out_type", 64'(fault_type_o), 64'd2);
    clr_fault();

    // Lock bit makes M subject to the permissions.
    cfg = '0; pa = '0;
    set_entry(0, 8'h98, 32'h2000_01FF);
    send(32'h8000_0010, 2'd2, 1, 0, 0, 2'b11, lat);
    chk("lock_allow", 64'(rsp_allow_o), 64'd0);
    take_rsp();
    clr_fault();
    set_entry(0, 8'h18, 32'h2000_01FF);
    send(32'h8000_0010, 2'd2, 1, 0, 0, 2'b11, lat);
    chk("unlock_allow", 64'(rsp_allow_o), 64'd1);
    take_rsp();

    // NA4 at 0x100, R only: contained 2B access vs one crossing the end.
    cfg = '0; pa = '0;
    set_entry(2, 8'h11, 32'h0000_0040);
    send(32'h0000_0102, 2'd1, 1, 0, 0, 2'b00, lat);
    chk("na4_idx", 64'(rsp_idx_o), 64'd2);
    chk("na4_allow", 64'(rsp_allow_o), 64'd1);
    take_rsp();
    send(32'h0000_0103, 2'd1, 1, 0, 0, 2'b00, lat);
    chk("na4_partial_matched", 64'(rsp_matched_o), 64'd1);
    chk("na4_partial_allow", 64'(rsp_allow_o), 64'd0);
    take_rsp();
    clr_fault();

    // Sticky fault, backpressure, clear racing a new deny.
    cfg = '0; pa = '0;
    send(32'h0000_0100, 2'd2, 1, 0, 0, 2'b00, lat);
    take_rsp();
    chk("sticky_first", 64'(fault_addr_o), 64'h100);
    send(32'h0000_0200, 2'd2, 1, 0, 0, 2'b00, lat);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk("bp_valid", 64'(rsp_valid_o), 64'd1);
      chk("bp_allow", 64'(rsp_allow_o), 64'd0);
      chk("bp_matched", 64'(rsp_matched_o), 64'd0);
    end
    take_rsp();
    chk("sticky_keep_addr", 64'(fault_addr_o), 64'h100);
    chk("sticky_keep_valid", 64'(fault_valid_o), 64'd1);
    send(32'h0000_0300, 2'd2, 1, 0, 0, 2'b00, lat);
    @(negedge clk);
    rsp_ready = 1'b1;
    fault_clr = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    fault_clr = 1'b0;
    chk("clr_with_deny_addr", 64'(fault_addr_o), 64'h300);
    chk("clr_with_deny_valid", 64'(fault_valid_o), 64'd1);

    // Reset in the middle of a scan.
    @(negedge clk);
    req_addr = 32'h500; prv = 2'b00; req_r = 1'b1; req_w = 1'b0; req_x = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("scan_busy", 64'(busy_o), 64'd1);
    #2 rst = 1'b0;
    #1 chk("rst_scan_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_scan_busy", 64'(busy_o), 64'd0);
    chk("rst_scan_ready", 64'(req_ready_o), 64'd1);
    chk("rst_scan_fault", 64'(fault_valid_o), 64'd0);
    @(negedge clk) rst = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("rst_no_rsp", 64'(rsp_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
